// File: rtl/ofmaps_axis_tx.sv
// Ofmap output path: FWFT FIFO feeding an AXI-Stream master with per-row TLAST and a status word.
// Optional OFMAPS_RELU_EN clamps negative words to zero before they enter the FIFO.
module ofmaps_axis_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH      = 4,
    parameter int DIM_WIDTH            = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DIM_WIDTH-1:0]            ofmaps_width,
    input  logic [DIM_WIDTH-1:0]            ofmaps_height,
    input  logic                            ofmap_valid,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] ofmap_data,
    output logic                            ofmap_ready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [31:0]                     status
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DIM_WIDTH-1:0]       DIM_ONE  = 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                            state_q, state_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]          count_q, count_d;
    logic [DIM_WIDTH-1:0]              col_q, col_d, row_q, row_d;
    logic [DIM_WIDTH-1:0]              width_q, width_d, height_q, height_d;
    logic                              done_q, done_d, ovf_q, ovf_d;

    logic                              full, empty, wr_en, rd_en;
    logic                              start_frame, last_col, last_beat;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   din;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign start_frame = (state_q == IDLE) && start;
    assign last_col    = (col_q == width_q);
    assign last_beat   = last_col && (row_q == height_q);
    assign wr_en       = ofmap_ready && ofmap_valid;
    assign rd_en       = m_axis_tvalid && m_axis_tready;

`ifdef OFMAPS_RELU_EN
    assign din = ofmap_data[C_M_AXIS_TDATA_WIDTH-1] ? '0 : ofmap_data;
`else
    assign din = ofmap_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (rd_en && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ofmap_ready   = 1'b0;
        m_axis_tvalid = 1'b0;
        if (state_q == STREAM) begin
            ofmap_ready   = !full;
            m_axis_tvalid = !empty;
        end
    end

    // Head word is gated so the bus reads zero whenever nothing is offered.
    assign m_axis_tdata = m_axis_tvalid ? mem[rd_ptr_q] : '0;
    assign m_axis_tlast = m_axis_tvalid && last_col;

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        col_d    = col_q;
        row_d    = row_q;
        width_d  = width_q;
        height_d = height_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        if (start_frame) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            col_d    = '0;
            row_d    = '0;
            width_d  = ofmaps_width;
            height_d = ofmaps_height;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (last_col) begin
                    col_d = '0;
                    // Row saturates on the final beat so it never passes the frame height.
                    if (row_q != height_q) row_d = row_q + DIM_ONE;
                end else begin
                    col_d = col_q + DIM_ONE;
                end
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if ((state_q == STREAM) && ofmap_valid && full) ovf_d = 1'b1;
            if (rd_en && last_beat) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            col_q    <= col_d;
            row_q    <= row_d;
            width_q  <= width_d;
            height_q <= height_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is not reset; occupancy and the tdata gate keep stale contents invisible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

    assign status = {6'd0, 9'(row_q), 9'(col_q), 3'd0,
                     ovf_q, empty, full, done_q, (state_q != IDLE)};

endmodule

// File: tb/tb_ofmaps_axis_tx.sv
// Scoreboard bench for ofmaps_axis_tx: accepted words are queued, stream beats are popped and compared.
module tb_ofmaps_axis_tx;

    logic        clk = 1'b0;
    logic        rst, start, ofmap_valid, ofmap_ready;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [8:0]  ofmaps_width, ofmaps_height;
    logic [31:0] ofmap_data, m_axis_tdata, status;

    ofmaps_axis_tx dut (
        .clk(clk), .rst(rst), .start(start),
        .ofmaps_width(ofmaps_width), .ofmaps_height(ofmaps_height),
        .ofmap_valid(ofmap_valid), .ofmap_data(ofmap_data), .ofmap_ready(ofmap_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .status(status)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          beats = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_word;
    logic [8:0]  m_w = '0, m_h = '0, m_col = '0, m_row = '0;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef OFMAPS_RELU_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    // Samples on the falling edge: predicts the handshakes of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_axis_tvalid), 32'd1);
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_last", 32'(m_axis_tlast), 32'(prev_last));
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (ofmap_valid && ofmap_ready) exp_q.push_back(relu(ofmap_data));
            if (m_axis_tvalid && m_axis_tready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("tdata", m_axis_tdata, exp_word);
                end
                check("tlast", 32'(m_axis_tlast), 32'(m_col == m_w));
                if (m_col == m_w) begin
                    m_col = '0;
                    if (m_row != m_h) m_row = m_row + 9'd1;
                end else begin
                    m_col = m_col + 9'd1;
                end
                beats++;
            end
        end
    end

    task automatic do_start(input logic [8:0] w, input logic [8:0] h);
        @(posedge clk); #1;
        ofmaps_width  = w;
        ofmaps_height = h;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_w   = w;
        m_h   = h;
        m_col = '0;
        m_row = '0;
        exp_q.delete();
    endtask

    task automatic push(input logic [31:0] d);
        bit ok = 1'b0;
        ofmap_valid = 1'b1;
        ofmap_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ofmap_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_accept", 32'(ofmap_ready), 32'd1);
        @(posedge clk); #1;
        ofmap_valid = 1'b0;
    endtask

    // Returns on the rising edge of the target handshake.
    task automatic wait_beats(input int target, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (beats >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_timeout", beats, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; ofmap_valid = 1'b0; ofmap_data = '0;
        m_axis_tready = 1'b0; ofmaps_width = '0; ofmaps_height = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_status", status, 32'h8);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_ready", 32'(ofmap_ready), 32'd0);

        // IDLE ignores offered words and does not flag overflow.
        ofmap_valid = 1'b1; ofmap_data = 32'h1234;
        repeat (2) @(posedge clk);
        #1 ofmap_valid = 1'b0;
        check("idle_status", status, 32'h8);

        // Two rows of four beats; width changed after start must be ignored.
        m_axis_tready = 1'b1;
        do_start(9'd3, 9'd1);
        ofmaps_width = 9'd0;
        base = beats;
        for (int i = 1; i <= 8; i++) push(32'(i));
        wait_beats(base + 8, 100);
        #1;
        check("t1_busy_done", 32'(status[0]), 32'd1);
        check("t1_frame_done", 32'(status[1]), 32'd1);
        @(posedge clk); #1;
        check("t1_idle", 32'(status[0]), 32'd0);
        check("t1_done_sticky", 32'(status[1]), 32'd1);
        check("t1_empty", 32'(status[3]), 32'd1);
        check("t1_col", 32'(status[16:8]), 32'd0);

        // Fill while stalled, overflow on the 17th, then drain.
        m_axis_tready = 1'b0;
        do_start(9'd15, 9'd0);
        check("t2_done_cleared", 32'(status[1]), 32'd0);
        base = beats;
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
        check("t2_ready_low", 32'(ofmap_ready), 32'd0);
        check("t2_full", 32'(status[2]), 32'd1);
        check("t2_no_ovf_yet", 32'(status[4]), 32'd0);
        ofmap_valid = 1'b1; ofmap_data = 32'h117;
        @(posedge clk); #1 ofmap_valid = 1'b0;
        check("t2_overflow", 32'(status[4]), 32'd1);
        m_axis_tready = 1'b1;
        wait_beats(base + 16, 100);
        #1;
        check("t2_empty", 32'(status[3]), 32'd1);
        repeat (3) @(posedge clk); #1;
        check("t2_beat_count", beats, base + 16);
        check("t2_ovf_sticky", 32'(status[4]), 32'd1);

        // Toggle tready against a full FIFO.
        m_axis_tready = 1'b0;
        do_start(9'd7, 9'd1);
        check("t3_ovf_cleared", 32'(status[4]), 32'd0);
        base = beats;
        for (int i = 0; i < 16; i++) push(32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 200 && beats < base + 16; i++) begin
            @(posedge clk); #1;
            m_axis_tready = ~m_axis_tready;
        end
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("t3_beat_count", beats, base + 16);
        check("t3_done", 32'(status[1]), 32'd1);
        check("t3_empty", 32'(status[3]), 32'd1);

        // Reset mid-frame, then a fresh frame restarts the counters.
        m_axis_tready = 1'b0;
        do_start(9'd3, 9'd1);
        base = beats;
        for (int i = 0; i < 8; i++) push(32'hAB00 + 32'(i));
        m_axis_tready = 1'b1;
        wait_beats(base + 5, 100);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("t4_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t4_status", status, 32'h8);
        rst = 1'b0;
        exp_q.delete();
        do_start(9'd3, 9'd1);
        base = beats;
        for (int i = 0; i < 8; i++) push(32'hCD00 + 32'(i));
        wait_beats(base + 8, 100);
        #1;
        check("t4_done", 32'(status[1]), 32'd1);

        // Single-beat frame.
        do_start(9'd0, 9'd0);
        base = beats;
        push(32'hA5);
        wait_beats(base + 1, 50);
        #1;
        check("t5_done", 32'(status[1]), 32'd1);
        check("t5_busy", 32'(status[0]), 32'd1);
        @(posedge clk); #1;
        check("t5_idle", 32'(status[0]), 32'd0);

        // Sign handling: clamped only when the ReLU option is built in.
        do_start(9'd1, 9'd0);
        base = beats;
        push(32'hFFFF_FFFF);
        push(32'h0000_0005);
        wait_beats(base + 2, 50);
        #1;
        check("t6_done", 32'(status[1]), 32'd1);
        check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
